// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the uart_rx receiver.
//   rx_state_t : receiver FSM states (PARITY used only when UART_RX_PARITY_EN is defined)
//   BAUD_W     : baud counter width
//   DATA_BITS  : data bits per frame
package uart_rx_pkg;

    localparam int BAUD_W    = 16;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep flop chain for an asynchronous input pin.
// All stages preset to 1 on reset so an idle (high) line looks idle at once.
//   clk : sampling clock
//   rst : synchronous, active-high reset (presets the chain to 1)
//   d   : raw asynchronous input
//   q   : synchronised output, SYNC_STAGES cycles behind d
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '1;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous 8N1 serial receiver (8E1 with UART_RX_PARITY_EN defined).
// Samples each bit at mid-bit and delivers one byte per frame as a one-cycle strobe.
//   clk_10     : system clock
//   rst        : synchronous, active-high reset
//   uart       : raw serial line, idle high
//   data       : last good byte; held until the next good frame
//   data_valid : one-cycle strobe, data valid this cycle
//   frame_err  : one-cycle strobe, stop bit sampled low
//   parity_err : one-cycle strobe, parity mismatch (constant 0 unless UART_RX_PARITY_EN)
//   busy       : FSM is not in IDLE
// Optional feature macro: UART_RX_PARITY_EN
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_10,
    input  logic       rst,
    input  logic       uart,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // Terminal counts: START waits half a bit to land on the start-bit centre,
    // every later state waits a full bit from there.
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [BAUD_W-1:0]    cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk_10),
        .rst (rst),
        .d   (uart),
        .q   (rx_s)
    );

    assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk_10) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        // Line back high at mid-start: a glitch, not a frame.
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        // Even parity: data bits XOR parity bit must be 0.
                        par_bad <= (^shreg) ^ rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Back to IDLE at mid-stop so a start edge half a
                            // bit later is still caught.
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                data       <= shreg;
                                data_valid <= 1'b1;
                            end
`else
                            data       <= shreg;
                            data_valid <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Held-low line: wait for idle instead of decoding 0x00s.
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Drives serial frames bit by bit
// and compares received strobes against an expected byte queue and error counts.
module tb_uart_rx;

    localparam int BIT = 87;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk_10 = 1'b0;
    logic       rst    = 1'b1;
    logic       uart   = 1'b1;
    logic [7:0] data;
    logic       data_valid, frame_err, parity_err, busy;

    uart_rx #(.CLKS_PER_BIT(BIT), .SYNC_STAGES(2)) dut (
        .clk_10     (clk_10),
        .rst        (rst),
        .uart       (uart),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #50 clk_10 = ~clk_10;

    int checks   = 0;
    int failures = 0;

    // Observed side
    logic [7:0] got_q[$];
    int         fe_cnt = 0, pe_cnt = 0, excl_viol = 0, hold_viol = 0;
    logic [7:0] prev_data = 8'h00;
    bit         ign = 1'b1;

    // Expected side
    logic [7:0] exp_q[$];
    int         fe_exp = 0, pe_exp = 0;
    logic [7:0] exp_data = 8'h00;

    always @(negedge clk_10) begin
        if (data_valid) got_q.push_back(data);
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1)
            excl_viol <= excl_viol + 1;
        if (!ign && !data_valid && data !== prev_data)
            hold_viol <= hold_viol + 1;
        prev_data <= data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart = v;
        repeat (BIT) @(negedge clk_10);
    endtask

    // Send one frame and record what the receiver should report for it.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR) drive_bit((^b) ^ par_flip);
        drive_bit(stop_bit);
        if (!stop_bit)             fe_exp++;
        else if (PAR && par_flip)  pe_exp++;
        else begin
            exp_q.push_back(b);
            exp_data = b;
        end
    endtask

    task automatic idle(input int n);
        uart = 1'b1;
        repeat (n) @(negedge clk_10);
    endtask

    task automatic check_all(input string tag);
        idle(10);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({tag, "_fe"},   fe_cnt, fe_exp);
        check({tag, "_pe"},   pe_cnt, pe_exp);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_viol"}, excl_viol + hold_viol, 0);
    endtask

    initial begin
        int quiet_bad, busy_cnt;
        logic [7:0] b;
        logic sb, pf;

        // Reset, then a long idle line
        repeat (3) @(negedge clk_10);
        rst = 1'b0;
        @(negedge clk_10);
        ign = 1'b0;
        check("rst_data", data, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_pe", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        quiet_bad = 0;
        for (int i = 0; i < 2000; i++) begin
            if (data_valid || frame_err || parity_err || busy || data != 8'h00) quiet_bad++;
            @(negedge clk_10);
        end
        check("idle_quiet", quiet_bad, 0);

        // Two back-to-back frames, no gap
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h3F, 1'b1, 1'b0);
        check_all("b2b");

        // Short low glitch is rejected
        busy_cnt = 0;
        uart = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk_10);
        end
        uart = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk_10);
        end
        check("glitch_seen", busy_cnt > 0, 1'b1);
        check("glitch_busy_le45", busy_cnt <= 45, 1'b1);
        check("glitch_idle", busy, 1'b0);
        check_all("glitch");

        // Bad stop bit, line held low, then a good frame
        send_frame(8'hA3, 1'b0, 1'b0);
        uart = 1'b0;
        repeat (3 * BIT) @(negedge clk_10);
        idle(2 * BIT);
        check_all("break");
        send_frame(8'h01, 1'b1, 1'b0);
        check_all("after_break");

        // Reset pulse during data bit 4 of a 0xFF frame
        drive_bit(1'b0);
        uart = 1'b1;
        repeat (4 * BIT + BIT / 2) @(negedge clk_10);
        ign = 1'b1;
        rst = 1'b1;
        @(negedge clk_10);
        rst = 1'b0;
        exp_data = 8'h00;
        repeat (2) @(negedge clk_10);
        ign = 1'b0;
        idle(5 * BIT);
        check_all("midrst");
        send_frame(8'h7E, 1'b1, 1'b0);
        check_all("post_rst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b0);
        check_all("par_ok");
        send_frame(8'h03, 1'b1, 1'b1);
        check_all("par_bad");
`endif

        // Randomised frames; a bad stop is always followed by idle so the
        // BREAK wait does not swallow the next start bit.
        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            pf = ($urandom_range(0, 5) == 0);
            send_frame(b, sb, pf);
            if (!sb) idle(BIT + $urandom_range(0, BIT));
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2 * BIT));
        end
        check_all("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
